// File: rtl/vibrator_pulse_ctrl.sv
// vibrator_pulse_ctrl: multi-channel vibration-motor controller.
// Each channel runs independently. It supports a latched continuous mode
// (HOLD) and a timed burst mode made of N ON phases separated by OFF phases.
// One shared prescaler generates the timing tick for all channels.
// The optional intensity PWM is built only when VIBRATOR_PWM_EN is defined.
// Without it, the duty input is ignored and shake follows the ON/HOLD state.
module vibrator_pulse_ctrl #(
  parameter int CH_NUM   = 2,
  parameter int TICK_DIV = 50000,
  parameter int TIME_W   = 10,
  parameter int CNT_W    = 4,
  parameter int PWM_W    = 4
) (
  input  logic              clk_50M,
  input  logic              s_rst_n,
  input  logic [CH_NUM-1:0] shake_open,
  input  logic [CH_NUM-1:0] shake_close,
  input  logic [CH_NUM-1:0] pulse_start,
  input  logic [TIME_W-1:0] on_ms,
  input  logic [TIME_W-1:0] off_ms,
  input  logic [CNT_W-1:0]  burst_cnt,
  input  logic [PWM_W-1:0]  duty,
  output logic [CH_NUM-1:0] shake,
  output logic [CH_NUM-1:0] busy,
  output logic [CH_NUM-1:0] done
);

  localparam int PRE_W = $clog2(TICK_DIV);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_ON   = 2'd2,
    ST_OFF  = 2'd3
  } state_t;

  // A programmed duration of zero ticks behaves as a duration of one tick.
  function automatic logic [TIME_W-1:0] at_least_one(input logic [TIME_W-1:0] v);
    return (v == '0) ? TIME_W'(1) : v;
  endfunction

  logic [1:0]       rst_pipe;
  logic             rst_n;
  logic [PRE_W-1:0] pre_cnt;
  logic             tick;
  logic             pwm_gate;

  // Reset synchronizer. Reset asserts asynchronously and is released on a clock edge.
  always_ff @(posedge clk_50M or negedge s_rst_n) begin
    if (!s_rst_n) rst_pipe <= '0;
    else          rst_pipe <= {rst_pipe[0], 1'b1};
  end

  assign rst_n = rst_pipe[1];

  // Shared free-running prescaler. It is never restarted, so the first tick
  // of any phase can arrive after only part of a full tick period.
  always_ff @(posedge clk_50M or negedge rst_n) begin
    // NOTE: every register here is clocked, so it is written with non-blocking
    // assignments. Blocking assignments would race with the other flops that
    // sample the same edge.
    if (!rst_n)    pre_cnt <= '0;
    else if (tick) pre_cnt <= '0;
    else           pre_cnt <= pre_cnt + PRE_W'(1);
  end

  assign tick = (pre_cnt == PRE_LAST);

`ifdef VIBRATOR_PWM_EN
  logic [PWM_W-1:0] pwm_cnt;

  // Shared intensity counter. It wraps freely and all channels see the same phase.
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) pwm_cnt <= '0;
    else        pwm_cnt <= pwm_cnt + PWM_W'(1);
  end

  assign pwm_gate = (duty == '1) || (pwm_cnt < duty);
`else
  logic unused_duty;

  assign pwm_gate    = 1'b1;
  assign unused_duty = ^duty;
`endif

  for (genvar g = 0; g < CH_NUM; g++) begin : gen_ch
    state_t            state, state_nx;
    logic [TIME_W-1:0] timer, timer_nx;
    logic [TIME_W-1:0] on_len, on_len_nx;
    logic [TIME_W-1:0] off_len, off_len_nx;
    logic [CNT_W-1:0]  rep, rep_nx;
    logic              done_nx;
    logic              drive_nx;
    logic              shake_r, busy_r, done_r;

    // Next-state logic. Requests are ranked open > close > pulse_start;
    // otherwise the burst phase timers advance on each tick.
    always_comb begin
      // NOTE: every signal gets a default before the branches. That way, no
      // path leaves one unassigned, and no latch is inferred.
      state_nx   = state;
      timer_nx   = timer;
      on_len_nx  = on_len;
      off_len_nx = off_len;
      rep_nx     = rep;
      done_nx    = 1'b0;

      if (shake_open[g]) begin
        state_nx = ST_HOLD;
      end else if (shake_close[g]) begin
        state_nx = ST_IDLE;
      end else if (pulse_start[g]) begin
        on_len_nx  = on_ms;
        off_len_nx = off_ms;
        rep_nx     = burst_cnt;
        if (burst_cnt == '0) begin
          state_nx = ST_IDLE;
          done_nx  = 1'b1;
        end else begin
          state_nx = ST_ON;
          timer_nx = at_least_one(on_ms);
        end
      end else begin
        unique case (state)
          ST_ON: begin
            if (tick) begin
              if (timer <= TIME_W'(1)) begin
                rep_nx = rep - CNT_W'(1);
                if (rep <= CNT_W'(1)) begin
                  state_nx = ST_IDLE;
                  done_nx  = 1'b1;
                end else begin
                  state_nx = ST_OFF;
                  timer_nx = at_least_one(off_len);
                end
              end else begin
                timer_nx = timer - TIME_W'(1);
              end
            end
          end
          ST_OFF: begin
            if (tick) begin
              if (timer <= TIME_W'(1)) begin
                state_nx = ST_ON;
                timer_nx = at_least_one(on_len);
              end else begin
                timer_nx = timer - TIME_W'(1);
              end
            end
          end
          default: ;
        endcase
      end
    end

    assign drive_nx = (state_nx == ST_HOLD) || (state_nx == ST_ON);

    // Channel registers. The outputs are registered from the next state, so
    // a request sampled at one edge appears on the outputs at that same edge.
    always_ff @(posedge clk_50M or negedge rst_n) begin
      if (!rst_n) begin
        state   <= ST_IDLE;
        timer   <= '0;
        on_len  <= '0;
        off_len <= '0;
        rep     <= '0;
        shake_r <= 1'b0;
        busy_r  <= 1'b0;
        done_r  <= 1'b0;
      end else begin
        state   <= state_nx;
        timer   <= timer_nx;
        on_len  <= on_len_nx;
        off_len <= off_len_nx;
        rep     <= rep_nx;
        shake_r <= drive_nx & pwm_gate;
        busy_r  <= (state_nx != ST_IDLE);
        done_r  <= done_nx;
      end
    end

    assign shake[g] = shake_r;
    assign busy[g]  = busy_r;
    assign done[g]  = done_r;
  end

endmodule

// File: tb/tb_vibrator_pulse_ctrl.sv
// Testbench for vibrator_pulse_ctrl with TICK_DIV=10 and two channels.
// An abstract model describes a burst as a count of ticks elapsed since its
// start. It is compared against the DUT outputs on every cycle. Directed
// sequences add literal expectations for pulse lengths and special cases.
// The PWM checks are built when VIBRATOR_PWM_EN is defined.
module tb_vibrator_pulse_ctrl;
  localparam int CH = 2;
  localparam int TD = 10;
  localparam int TW = 10;
  localparam int CW = 4;
  localparam int PW = 4;

  localparam int M_IDLE  = 0;
  localparam int M_HOLD  = 1;
  localparam int M_BURST = 2;

  logic          clk_50M = 1'b0;
  logic          s_rst_n = 1'b0;
  logic [CH-1:0] shake_open  = '0;
  logic [CH-1:0] shake_close = '0;
  logic [CH-1:0] pulse_start = '0;
  logic [TW-1:0] on_ms       = '0;
  logic [TW-1:0] off_ms      = '0;
  logic [CW-1:0] burst_cnt   = '0;
  logic [PW-1:0] duty        = 4'hF;
  logic [CH-1:0] shake, busy, done;

  vibrator_pulse_ctrl #(
    .CH_NUM(CH), .TICK_DIV(TD), .TIME_W(TW), .CNT_W(CW), .PWM_W(PW)
  ) dut (
    .clk_50M    (clk_50M),
    .s_rst_n    (s_rst_n),
    .shake_open (shake_open),
    .shake_close(shake_close),
    .pulse_start(pulse_start),
    .on_ms      (on_ms),
    .off_ms     (off_ms),
    .burst_cnt  (burst_cnt),
    .duty       (duty),
    .shake      (shake),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk_50M = ~clk_50M;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    tests++;
    if (act < lo || act > hi) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d..%0d at %0t", name, act, lo, hi, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int            m_mode[CH], m_on[CH], m_off[CH], m_cnt[CH], m_n[CH];
  int            m_pre, m_rel, m_pwm;
  bit            m_tick, m_drive;
  logic [CH-1:0] exp_shake = '0, exp_busy = '0, exp_done = '0;

  // A burst is tracked as n ticks since its start. Shake is high while
  // n mod (on+off) < on, and the burst ends when n reaches cnt*on + (cnt-1)*off.
  // Two clock edges after the reset release are spent inside the synchronizer.
  always @(posedge clk_50M or negedge s_rst_n) begin
    if (!s_rst_n) begin
      for (int c = 0; c < CH; c++) begin
        m_mode[c] = M_IDLE; m_n[c] = 0; m_on[c] = 1; m_off[c] = 1; m_cnt[c] = 0;
      end
      exp_shake = '0; exp_busy = '0; exp_done = '0;
      m_pre = 0; m_rel = 0; m_pwm = 0;
    end else if (m_rel < 2) begin
      m_rel++;
    end else begin
      m_tick = (m_pre == TD - 1);
      for (int c = 0; c < CH; c++) begin
        exp_done[c] = 1'b0;
        if (shake_open[c]) begin
          m_mode[c] = M_HOLD;
        end else if (shake_close[c]) begin
          m_mode[c] = M_IDLE;
        end else if (pulse_start[c]) begin
          m_on[c]  = (on_ms == 0) ? 1 : int'(on_ms);
          m_off[c] = (off_ms == 0) ? 1 : int'(off_ms);
          m_cnt[c] = int'(burst_cnt);
          m_n[c]   = 0;
          if (m_cnt[c] == 0) begin
            m_mode[c] = M_IDLE;
            exp_done[c] = 1'b1;
          end else begin
            m_mode[c] = M_BURST;
          end
        end else if (m_mode[c] == M_BURST && m_tick) begin
          m_n[c]++;
          if (m_n[c] == m_cnt[c] * m_on[c] + (m_cnt[c] - 1) * m_off[c]) begin
            m_mode[c] = M_IDLE;
            exp_done[c] = 1'b1;
          end
        end
        m_drive = (m_mode[c] == M_HOLD) ||
                  (m_mode[c] == M_BURST && (m_n[c] % (m_on[c] + m_off[c])) < m_on[c]);
`ifdef VIBRATOR_PWM_EN
        m_drive = m_drive && (duty == 4'hF || m_pwm < int'(duty));
`endif
        exp_shake[c] = m_drive;
        exp_busy[c]  = (m_mode[c] != M_IDLE);
      end
      m_pre = (m_pre + 1) % TD;
      m_pwm = (m_pwm + 1) % 16;
    end
  end

  // Per-cycle comparison on the falling edge, away from the active edge.
  bit cmp_en = 1'b0;
  always @(negedge clk_50M) begin
    if (cmp_en) begin
      check("model_shake", 32'(shake), 32'(exp_shake));
      check("model_busy",  32'(busy),  32'(exp_busy));
      check("model_done",  32'(done),  32'(exp_done));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk_50M);
  endtask

  task automatic start_burst(input int c, input int on, input int off, input int cnt);
    on_ms = TW'(on); off_ms = TW'(off); burst_cnt = CW'(cnt);
    pulse_start[c] = 1'b1;
    @(negedge clk_50M);
    pulse_start = '0;
  endtask

  task automatic pulse_open(input int c);
    shake_open[c] = 1'b1;
    @(negedge clk_50M);
    shake_open = '0;
  endtask

  task automatic pulse_close(input int c);
    shake_close[c] = 1'b1;
    @(negedge clk_50M);
    shake_close = '0;
  endtask

  int   hi_len[$];
  int   lo_len[$];
  int   run, dcnt, len;
  logic prev;

  initial begin
    // ---- reset state ----
    cyc(3);
    check("reset_shake", 32'(shake), 0);
    check("reset_busy",  32'(busy),  0);
    check("reset_done",  32'(done),  0);
    s_rst_n = 1'b1;
    cyc(4);
    cmp_en = 1'b1;

    // ---- continuous open / close ----
    pulse_open(0);
    check("open_shake0", 32'(shake[0]), 1);
    check("open_ch1_untouched", 32'(shake[1]), 0);
    cyc(20);
    check("hold_keeps_shake", 32'(shake[0]), 1);
    pulse_close(0);
    check("close_shake0", 32'(shake[0]), 0);
    check("close_busy0",  32'(busy[0]),  0);
    cyc(3);

    // ---- burst on=2 off=3 cnt=3 on channel 1 ----
    start_burst(1, 2, 3, 3);
    prev = 1'b1; run = 0; dcnt = 0;
    for (int i = 0; i < 200; i++) begin
      if (shake[1] === prev) run++;
      else begin
        if (prev) hi_len.push_back(run); else lo_len.push_back(run);
        prev = shake[1]; run = 1;
      end
      if (done[1] === 1'b1) begin
        dcnt++;
        check("burst_busy_falls_with_done", 32'(busy[1]), 0);
      end
      @(negedge clk_50M);
    end
    check("burst_high_count", 32'(hi_len.size()), 3);
    check("burst_low_count",  32'(lo_len.size()), 2);
    foreach (hi_len[i]) check_range("burst_high_len", hi_len[i], 11, 20);
    foreach (lo_len[i]) check_range("burst_low_len",  lo_len[i], 21, 30);
    check("burst_done_once", 32'(dcnt), 1);

    // ---- open and close in the same cycle: open wins ----
    shake_open[0] = 1'b1; shake_close[0] = 1'b1;
    @(negedge clk_50M);
    shake_open = '0; shake_close = '0;
    check("open_beats_close", 32'(shake[0]), 1);
    pulse_close(0);

    // ---- close during a burst: no done ----
    start_burst(0, 2, 2, 2);
    cyc(5);
    pulse_close(0);
    check("close_in_burst_shake", 32'(shake[0]), 0);
    dcnt = 0;
    for (int i = 0; i < 50; i++) begin
      if (done[0] === 1'b1) dcnt++;
      @(negedge clk_50M);
    end
    check("close_in_burst_no_done", 32'(dcnt), 0);

    // ---- open during OFF: goes to HOLD, no done ----
    start_burst(0, 1, 3, 2);
    len = 0;
    while (shake[0] !== 1'b0 && len < 40) begin
      len++;
      @(negedge clk_50M);
    end
    check_range("reach_off_phase", len, 1, 10);
    pulse_open(0);
    check("open_in_off_shake", 32'(shake[0]), 1);
    dcnt = 0;
    for (int i = 0; i < 60; i++) begin
      if (done[0] === 1'b1) dcnt++;
      @(negedge clk_50M);
    end
    check("open_in_off_no_done", 32'(dcnt), 0);
    check("open_in_off_holds", 32'(shake[0]), 1);
    pulse_close(0);

    // ---- empty burst ----
    start_burst(1, 2, 2, 0);
    check("empty_burst_shake", 32'(shake[1]), 0);
    check("empty_burst_done",  32'(done[1]),  1);
    check("empty_burst_busy",  32'(busy[1]),  0);
    cyc(1);
    check("empty_burst_done_single", 32'(done[1]), 0);

    // ---- zero on_ms: one-tick ON phase ----
    start_burst(0, 0, 0, 1);
    len = 0;
    while (shake[0] === 1'b1 && len < 30) begin
      len++;
      @(negedge clk_50M);
    end
    check_range("zero_on_len", len, 1, 10);

    // ---- retrigger mid-ON restarts the count ----
    start_burst(1, 3, 1, 1);
    cyc(15);
    start_burst(1, 3, 1, 1);
    len = 0;
    while (shake[1] === 1'b1 && len < 60) begin
      len++;
      @(negedge clk_50M);
    end
    check_range("retrigger_len", len, 21, 30);

    // ---- reset in the middle of a burst ----
    start_burst(0, 3, 3, 3);
    cyc(7);
    @(posedge clk_50M);
    #2 s_rst_n = 1'b0;
    #1;
    check("midreset_shake", 32'(shake), 0);
    check("midreset_busy",  32'(busy),  0);
    check("midreset_done",  32'(done),  0);
    @(negedge clk_50M);
    s_rst_n = 1'b1;
    cyc(4);
    check("after_reset_idle", 32'(busy), 0);

`ifdef VIBRATOR_PWM_EN
    // ---- intensity PWM in HOLD ----
    duty = 4'd4;
    pulse_open(0);
    len = 0;
    for (int i = 0; i < 32; i++) begin
      if (shake[0] === 1'b1) len++;
      @(negedge clk_50M);
    end
    check("pwm_duty4", 32'(len), 8);
    duty = 4'hF;
    cyc(1);
    len = 0;
    for (int i = 0; i < 32; i++) begin
      if (shake[0] === 1'b1) len++;
      @(negedge clk_50M);
    end
    check("pwm_duty15", 32'(len), 32);
    duty = 4'd0;
    cyc(1);
    len = 0;
    for (int i = 0; i < 32; i++) begin
      if (shake[0] === 1'b1) len++;
      @(negedge clk_50M);
    end
    check("pwm_duty0", 32'(len), 0);
    check("pwm_duty0_busy", 32'(busy[0]), 1);
    pulse_close(0);
    duty = 4'hF;
`endif

    // ---- randomized traffic against the model ----
    for (int i = 0; i < 6000; i++) begin
      on_ms     = TW'($urandom_range(0, 3));
      off_ms    = TW'($urandom_range(0, 3));
      burst_cnt = CW'($urandom_range(0, 3));
      duty      = PW'($urandom_range(0, 15));
      for (int c = 0; c < CH; c++) begin
        shake_open[c]  = ($urandom_range(0, 399) == 0);
        shake_close[c] = ($urandom_range(0, 299) == 0);
        pulse_start[c] = ($urandom_range(0, 59) == 0);
      end
      @(negedge clk_50M);
    end
    shake_open = '0; shake_close = '0; pulse_start = '0;
    cyc(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
